// File: rtl/timer_regs.sv
// -----------------------------------------------------------------------------
// timer_regs -- Game Boy timer peripheral (DIV / TIMA / TMA / TAC)
//
// Bus responder on the CPU system bus. It exposes four byte registers starting
// at BASE_ADDR:
//   +0 DIV  : upper byte of a free-running 16-bit divider; any write clears it
//   +1 TIMA : timer counter, incremented on falling edges of the selected tick
//   +2 TMA  : reload value loaded into TIMA after an overflow
//   +3 TAC  : {enable, clock select[1:0]}; upper five bits read back as 1
//
// When TIMA overflows it reads 0x00 for RELOAD_DELAY clocks. On the last clock
// of that window it is loaded from TMA and irq pulses for exactly one clock.
//
// Ports:
//   clk         in   1  system clock (4 MHz T-cycle rate)
//   reset       in   1  synchronous, active-high reset
//   t_cycle     in   2  CPU T-cycle phase; writes commit on the edge with t_cycle==3
//   mem_addr    in  16  CPU bus address
//   mem_enable  in   1  CPU bus access enable
//   mem_write   in   1  CPU bus write enable
//   mem_wdata   in   8  CPU write data
//   rdata       out  8  combinational read data, 8'hFF when not read-selected
//   selected    out  1  combinational, address hits BASE_ADDR..BASE_ADDR+3
//   irq         out  1  registered timer interrupt request, one-clock pulse
//   div_count   out 16  live divider value (only with TIMER_DIV_OUT_EN)
//
// Build option:
//   TIMER_DIV_OUT_EN  when defined, adds the div_count output so the APU frame
//                     sequencer and serial clock can share this divider.
// -----------------------------------------------------------------------------
module timer_regs #(
   parameter logic [15:0] BASE_ADDR    = 16'hFF04,
   parameter int unsigned RELOAD_DELAY = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  t_cycle,
   input  logic [15:0] mem_addr,
   input  logic        mem_enable,
   input  logic        mem_write,
   input  logic [7:0]  mem_wdata,
   output logic [7:0]  rdata,
   output logic        selected,
   output logic        irq
`ifdef TIMER_DIV_OUT_EN
   ,
   output logic [15:0] div_count
`endif
);

   // ---------------------------------------------------------------------------
   // Local types and constants
   // ---------------------------------------------------------------------------
   typedef enum logic [1:0] {
      REG_DIV  = 2'd0,
      REG_TIMA = 2'd1,
      REG_TMA  = 2'd2,
      REG_TAC  = 2'd3
   } reg_sel_e;

   localparam int unsigned         CNT_W       = $clog2(RELOAD_DELAY + 1);
   localparam logic [CNT_W-1:0]    RELOAD_INIT = CNT_W'(RELOAD_DELAY);
   localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);

   // Tick source: enable bit gated with one divider bit chosen by TAC[1:0].
   function automatic logic tick_of(input logic [15:0] div, input logic [2:0] tac);
      logic div_bit;
      case (tac[1:0])
         2'b00:   div_bit = div[9];   // 4096 Hz
         2'b01:   div_bit = div[3];   // 262144 Hz
         2'b10:   div_bit = div[5];   // 65536 Hz
         default: div_bit = div[7];   // 16384 Hz
      endcase
      return tac[2] & div_bit;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [15:0]      div_q,        div_d;
   logic [7:0]       tima_q,       tima_d;
   logic [7:0]       tma_q,        tma_d;
   logic [2:0]       tac_q,        tac_d;
   logic [CNT_W-1:0] reload_cnt_q, reload_cnt_d;
   logic             prev_tick_q,  tick;
   logic             irq_q,        irq_d;
   logic             tick_fall;

   // ---------------------------------------------------------------------------
   // Address decode and write strobes
   // ---------------------------------------------------------------------------
   logic [15:0] addr_offset;
   reg_sel_e    reg_sel;
   logic        wr;
   logic        wr_div, wr_tima, wr_tma, wr_tac;

   // Subtracting the base lets one compare cover the whole 4-byte window,
   // including addresses below BASE_ADDR which wrap to large offsets.
   assign addr_offset = mem_addr - BASE_ADDR;
   assign selected    = mem_enable & (addr_offset[15:2] == 14'd0);
   assign reg_sel     = reg_sel_e'(addr_offset[1:0]);

   assign wr      = selected & mem_write & (t_cycle == 2'd3);
   assign wr_div  = wr & (reg_sel == REG_DIV);
   assign wr_tima = wr & (reg_sel == REG_TIMA);
   assign wr_tma  = wr & (reg_sel == REG_TMA);
   assign wr_tac  = wr & (reg_sel == REG_TAC);

   // ---------------------------------------------------------------------------
   // Read mux
   // ---------------------------------------------------------------------------
   always_comb begin
      rdata = 8'hFF;
      if (selected && !mem_write) begin
         case (reg_sel)
            REG_DIV:  rdata = div_q[15:8];
            REG_TIMA: rdata = tima_q;
            REG_TMA:  rdata = tma_q;
            default:  rdata = {5'b11111, tac_q};
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned; that is what keeps this block from inferring latches.
      div_d        = div_q + 16'd1;
      tac_d        = tac_q;
      tma_d        = tma_q;
      tima_d       = tima_q;
      reload_cnt_d = reload_cnt_q;
      irq_d        = 1'b0;

      if (wr_div) div_d = 16'h0000;
      if (wr_tac) tac_d = mem_wdata[2:0];
      if (wr_tma) tma_d = mem_wdata;

      // The edge is taken on the post-update divider and TAC, so clearing DIV
      // or reprogramming TAC while the tick is high looks like a real edge.
      tick      = tick_of(div_d, tac_d);
      tick_fall = prev_tick_q & ~tick;

      if (reload_cnt_q != '0) begin
         // Overflow window: TIMA holds 0x00 and tick edges are swallowed.
         reload_cnt_d = reload_cnt_q - CNT_ONE;
         if (reload_cnt_q == CNT_ONE) begin
            // Reload clock: TMA (including a same-clock TMA write) beats any
            // TIMA write.
            tima_d = tma_d;
            irq_d  = 1'b1;
         end else if (wr_tima) begin
            // Early CPU write aborts the pending reload and its interrupt.
            tima_d       = mem_wdata;
            reload_cnt_d = '0;
         end
      end else if (wr_tima) begin
         // A CPU write takes priority over a coincident increment.
         tima_d = mem_wdata;
      end else if (tick_fall) begin
         if (tima_q == 8'hFF) begin
            tima_d       = 8'h00;
            reload_cnt_d = RELOAD_INIT;
         end else begin
            tima_d = tima_q + 8'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make every register sample the values
      // from before this edge, independent of statement order.
      if (reset) begin
         div_q        <= 16'h0000;
         tima_q       <= 8'h00;
         tma_q        <= 8'h00;
         tac_q        <= 3'b000;
         reload_cnt_q <= '0;
         prev_tick_q  <= 1'b0;
         irq_q        <= 1'b0;
      end else begin
         div_q        <= div_d;
         tima_q       <= tima_d;
         tma_q        <= tma_d;
         tac_q        <= tac_d;
         reload_cnt_q <= reload_cnt_d;
         prev_tick_q  <= tick;
         irq_q        <= irq_d;
      end
   end

   assign irq = irq_q;

`ifdef TIMER_DIV_OUT_EN
   assign div_count = div_q;
`endif

endmodule

// File: tb/tb_timer_regs.sv
// -----------------------------------------------------------------------------
// tb_timer_regs -- self-checking bench for timer_regs
//
// A behavioural model (plain integers) is stepped once per clock with the same
// bus inputs the DUT sees; irq, selected and rdata are compared every cycle.
// On top of that: a decode/read vector table, hand-written corner sequences
// with hard-coded expectations, and a randomized bus phase.
// -----------------------------------------------------------------------------
module tb_timer_regs;

   localparam logic [15:0] BASE   = 16'hFF04;
   localparam int          RELOAD = 4;

   logic        clk        = 1'b0;
   logic        reset      = 1'b1;
   logic [1:0]  t_cycle    = 2'd0;
   logic [15:0] mem_addr   = 16'h0000;
   logic        mem_enable = 1'b0;
   logic        mem_write  = 1'b0;
   logic [7:0]  mem_wdata  = 8'h00;
   wire  [7:0]  rdata;
   wire         selected;
   wire         irq;
`ifdef TIMER_DIV_OUT_EN
   wire  [15:0] div_count;
`endif

   timer_regs #(.BASE_ADDR(BASE), .RELOAD_DELAY(RELOAD)) dut (
      .clk        (clk),
      .reset      (reset),
      .t_cycle    (t_cycle),
      .mem_addr   (mem_addr),
      .mem_enable (mem_enable),
      .mem_write  (mem_write),
      .mem_wdata  (mem_wdata),
      .rdata      (rdata),
      .selected   (selected),
      .irq        (irq)
`ifdef TIMER_DIV_OUT_EN
      ,
      .div_count  (div_count)
`endif
   );

   always #5 clk = ~clk;

   int total     = 0;
   int bad       = 0;
   int irq_seen  = 0;

   // ---------------------------------------------------------------------------
   // Reference model: integer state advanced by the register-level rules
   // ---------------------------------------------------------------------------
   int m_div, m_tima, m_tma, m_tac, m_pending;
   bit m_irq;

   function automatic int tick_of(input int div, input int tac);
      int bit_pos [4];
      bit_pos = '{9, 3, 5, 7};
      if ((tac & 4) == 0) return 0;
      return (div >> bit_pos[tac & 3]) & 1;
   endfunction

   // Register index 0..3 for an enabled access inside the window, else -1.
   function automatic int reg_index(input logic [15:0] a, input logic en);
      int ai;
      ai = int'({16'h0000, a});
      if (!en) return -1;
      if (ai >= int'(BASE) && ai <= int'(BASE) + 3) return ai - int'(BASE);
      return -1;
   endfunction

   function automatic int model_read(input logic [15:0] a, input logic en, input logic we);
      int idx;
      idx = reg_index(a, en);
      if (idx < 0 || we) return 255;
      case (idx)
         0:       return (m_div >> 8) & 255;
         1:       return m_tima;
         2:       return m_tma;
         default: return 248 | m_tac;
      endcase
   endfunction

   task automatic model_reset();
      m_div = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_pending = 0; m_irq = 0;
   endtask

   // One clock of the model using the bus inputs currently on the pins.
   task automatic model_clock();
      int idx;
      bit w;
      int old_tick;
      int new_tma;
      int wd;
      idx      = reg_index(mem_addr, mem_enable);
      w        = (idx >= 0) && mem_write && (t_cycle == 2'd3);
      wd       = int'({24'h0, mem_wdata});
      old_tick = tick_of(m_div, m_tac);
      m_div    = (w && idx == 0) ? 0 : (m_div + 1) % 65536;
      if (w && idx == 3) m_tac = wd & 7;
      new_tma  = (w && idx == 2) ? wd : m_tma;
      m_irq    = 0;
      if (m_pending > 0) begin
         m_pending = m_pending - 1;
         if (m_pending == 0) begin
            m_tima = new_tma;
            m_irq  = 1;
         end else if (w && idx == 1) begin
            m_tima    = wd;
            m_pending = 0;
         end
      end else if (w && idx == 1) begin
         m_tima = wd;
      end else if (old_tick == 1 && tick_of(m_div, m_tac) == 0) begin
         if (m_tima == 255) begin
            m_tima    = 0;
            m_pending = RELOAD;
         end else begin
            m_tima = m_tima + 1;
         end
      end
      m_tma = new_tma;
   endtask

   // ---------------------------------------------------------------------------
   // Checking and bus helpers (inputs change just after the falling edge)
   // ---------------------------------------------------------------------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [15:0] a, input logic en, input logic we,
                        input logic [7:0] d, input logic [1:0] tc);
      mem_addr   = a;
      mem_enable = en;
      mem_write  = we;
      mem_wdata  = d;
      t_cycle    = tc;
      #1;
      check("irq", 32'(irq), 32'(m_irq));
      if (irq === 1'b1) irq_seen = irq_seen + 1;
      check("selected", 32'(selected), 32'(reg_index(a, en) >= 0));
`ifdef TIMER_DIV_OUT_EN
      check("div_count", 32'(div_count), 32'(m_div));
`endif
   endtask

   task automatic edge_step();
      @(posedge clk);
      if (reset) model_reset();
      else       model_clock();
      @(negedge clk);
   endtask

   task automatic bus_cycle(input logic [15:0] a, input logic en, input logic we,
                            input logic [7:0] d, input logic [1:0] tc);
      drive(a, en, we, d, tc);
      check("rdata", 32'(rdata), 32'(model_read(a, en, we)));
      edge_step();
   endtask

   task automatic wr(input int idx, input logic [7:0] d);
      bus_cycle(BASE + 16'(idx), 1'b1, 1'b1, d, 2'd3);
   endtask

   task automatic idle();
      bus_cycle(16'h0000, 1'b0, 1'b0, 8'h00, 2'd0);
   endtask

   task automatic rd_expect(input string name, input int idx, input logic [7:0] exp);
      drive(BASE + 16'(idx), 1'b1, 1'b0, 8'h00, 2'd0);
      check(name, 32'(rdata), 32'(exp));
      check("rdata", 32'(rdata), 32'(model_read(BASE + 16'(idx), 1'b1, 1'b0)));
      edge_step();
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      for (int i = 0; i < n; i++) begin
         drive(16'h0000, 1'b0, 1'b0, 8'h00, 2'd0);
         check("reset_rdata", 32'(rdata), 32'hFF);
         check("reset_selected", 32'(selected), 32'h0);
         edge_step();
      end
      reset = 1'b0;
   endtask

   // Reset, enable the 262144 Hz tick, load TMA, TIMA=0xFF, then idle until the
   // first falling edge of div[3] overflows TIMA. Leaves four reload clocks.
   task automatic overflow_setup(input logic [7:0] tma);
      do_reset(2);
      wr(3, 8'h05);
      wr(2, tma);
      wr(1, 8'hFF);
      repeat (13) idle();
   endtask

   // ---------------------------------------------------------------------------
   // Decode / read vector table
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [15:0] addr;
      logic        en;
      logic        we;
      logic [1:0]  tc;
      logic        exp_sel;
      logic [7:0]  exp_rdata;
   } vec_t;

   vec_t vecs [12];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base_irq;

      model_reset();
      @(negedge clk);

      // Idle after reset: DIV reaches 0x0400 after 1024 clocks.
      do_reset(2);
      base_irq = irq_seen;
      repeat (1024) idle();
      rd_expect("div_1024", 0, 8'h04);
      rd_expect("tima_idle", 1, 8'h00);
      rd_expect("tac_reset", 3, 8'hF8);
      check("irq_quiet_idle", 32'(irq_seen - base_irq), 32'd0);

      // Table-driven decode and read-back with known register contents.
      do_reset(2);
      wr(1, 8'h12);
      wr(2, 8'h34);
      wr(3, 8'h03);
      vecs[0]  = '{16'hFF03, 1'b1, 1'b0, 2'd0, 1'b0, 8'hFF};
      vecs[1]  = '{16'hFF04, 1'b1, 1'b0, 2'd0, 1'b1, 8'h00};
      vecs[2]  = '{16'hFF05, 1'b1, 1'b0, 2'd0, 1'b1, 8'h12};
      vecs[3]  = '{16'hFF06, 1'b1, 1'b0, 2'd0, 1'b1, 8'h34};
      vecs[4]  = '{16'hFF07, 1'b1, 1'b0, 2'd0, 1'b1, 8'hFB};
      vecs[5]  = '{16'hFF08, 1'b1, 1'b0, 2'd0, 1'b0, 8'hFF};
      vecs[6]  = '{16'hFF05, 1'b0, 1'b0, 2'd0, 1'b0, 8'hFF};
      vecs[7]  = '{16'hFF06, 1'b1, 1'b1, 2'd0, 1'b1, 8'hFF};
      vecs[8]  = '{16'hFFFF, 1'b1, 1'b0, 2'd0, 1'b0, 8'hFF};
      vecs[9]  = '{16'h0000, 1'b1, 1'b0, 2'd0, 1'b0, 8'hFF};
      vecs[10] = '{16'hFF07, 1'b1, 1'b1, 2'd1, 1'b1, 8'hFF};
      vecs[11] = '{16'hFF06, 1'b1, 1'b0, 2'd2, 1'b1, 8'h34};
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].addr, vecs[i].en, vecs[i].we, 8'hA5, vecs[i].tc);
         check($sformatf("tbl%0d_sel", i), 32'(selected), 32'(vecs[i].exp_sel));
         check($sformatf("tbl%0d_rdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
         edge_step();
      end

      // Two falling edges take TIMA 0xFE -> 0xFF -> 0x00, reload four clocks later.
      do_reset(2);
      wr(3, 8'h05);
      wr(2, 8'hF0);
      wr(1, 8'hFE);
      base_irq = irq_seen;
      repeat (32) idle();
      rd_expect("tima_overflow", 1, 8'h00);
      repeat (3) idle();
      rd_expect("tima_reloaded", 1, 8'hF0);
      check("irq_one_pulse", 32'(irq_seen - base_irq), 32'd1);

      // TIMA write two clocks after overflow cancels the reload and irq.
      overflow_setup(8'h00);
      idle();
      wr(1, 8'h33);
      base_irq = irq_seen;
      repeat (6) idle();
      rd_expect("tima_cancel", 1, 8'h33);
      check("irq_cancelled", 32'(irq_seen - base_irq), 32'd0);

      // TMA write on the reload clock is written through to TIMA.
      overflow_setup(8'h00);
      repeat (3) idle();
      base_irq = irq_seen;
      wr(2, 8'h77);
      rd_expect("tima_tma_through", 1, 8'h77);
      rd_expect("tma_written", 2, 8'h77);
      check("irq_tma_through", 32'(irq_seen - base_irq), 32'd1);

      // TIMA write on the reload clock is ignored; TMA wins.
      overflow_setup(8'h9A);
      repeat (3) idle();
      base_irq = irq_seen;
      wr(1, 8'h55);
      rd_expect("tima_write_ignored", 1, 8'h9A);
      check("irq_reload_wins", 32'(irq_seen - base_irq), 32'd1);

      // Reset mid-countdown drops the pending reload.
      overflow_setup(8'h9A);
      idle();
      base_irq = irq_seen;
      do_reset(1);
      repeat (6) idle();
      rd_expect("tima_after_reset", 1, 8'h00);
      check("irq_after_reset", 32'(irq_seen - base_irq), 32'd0);

      // DIV clear while div[3]=1 gives a spurious increment; with div[3]=0 none.
      do_reset(2);
      wr(3, 8'h05);
      wr(1, 8'h10);
      repeat (6) idle();
      wr(0, 8'h5A);
      rd_expect("tima_div_spurious", 1, 8'h11);
      rd_expect("div_cleared", 0, 8'h00);
      wr(0, 8'hAB);
      rd_expect("tima_div_no_edge", 1, 8'h11);
      // Disabling TAC while the tick is high is also a falling edge.
      repeat (7) idle();
      wr(3, 8'h01);
      rd_expect("tima_tac_spurious", 1, 8'h12);

      // Writes with t_cycle!=3, with mem_enable=0, or outside the window.
      bus_cycle(BASE + 16'd1, 1'b1, 1'b1, 8'h99, 2'd1);
      bus_cycle(BASE + 16'd2, 1'b1, 1'b1, 8'h66, 2'd2);
      bus_cycle(BASE + 16'd3, 1'b1, 1'b1, 8'h07, 2'd0);
      bus_cycle(BASE + 16'd1, 1'b0, 1'b1, 8'h99, 2'd3);
      bus_cycle(16'hFF08,     1'b1, 1'b1, 8'h55, 2'd3);
      rd_expect("tima_unchanged", 1, 8'h12);
      rd_expect("tma_unchanged", 2, 8'h00);
      rd_expect("tac_unchanged", 3, 8'hF9);

      // Randomized bus traffic around the register window.
      for (int n = 0; n < 3000; n++) begin
         int          r;
         logic [15:0] a;
         logic [7:0]  d;
         logic [1:0]  tc;
         r = int'($urandom_range(0, 99));
         if (r < 2) begin
            reset = 1'b1;
            idle();
            reset = 1'b0;
         end else begin
            a  = BASE - 16'd1 + 16'($urandom_range(0, 5));
            d  = 8'($urandom);
            if (a == BASE + 16'd1 && $urandom_range(0, 1) == 1) d = 8'hF8 | d;
            tc = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'($urandom_range(0, 3));
            bus_cycle(a, $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, d, tc);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
